// File: rtl/kd_tree_query_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : kd_tree_query_scheduler
// Function : Loads KD-tree split values, streams query patches through the
//            fixed-latency tree and buffers leaf indices under credit control.
// Revision : 1.0 - initial release
// ============================================================================
module kd_tree_query_scheduler #(
  parameter int INTERNAL_WIDTH = 22,
  parameter int PATCH_WIDTH    = 55,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int NUM_NODES      = 127,
  parameter int TREE_LATENCY   = 7,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic                      search_start,
  input  logic                      node_valid,
  output logic                      node_ready,
  input  logic [INTERNAL_WIDTH-1:0] node_data,
  input  logic                      query_valid,
  output logic                      query_ready,
  input  logic [PATCH_WIDTH-1:0]    query_patch,
  input  logic                      query_last,
  output logic                      tree_fsm_enable,
  output logic                      tree_sender_enable,
  output logic [INTERNAL_WIDTH-1:0] tree_sender_data,
  output logic [PATCH_WIDTH-1:0]    tree_patch,
  input  logic [ADDRESS_WIDTH-1:0]  tree_leaf_index,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [ADDRESS_WIDTH-1:0]  result_leaf,
  output logic                      result_last,
  output logic                      tree_loaded,
  output logic                      busy,
  output logic                      load_done,
  output logic                      search_done
);

  localparam int c_CNT_W = $clog2(NUM_NODES + 1);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_OUT_W = $clog2(TREE_LATENCY + FIFO_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_NODE = c_CNT_W'(NUM_NODES);
  localparam logic [c_OUT_W-1:0] c_CREDITS   = c_OUT_W'(FIFO_DEPTH);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LOAD   = 2'd1;
  localparam logic [1:0] c_SEARCH = 2'd2;
  localparam logic [1:0] c_DRAIN  = 2'd3;

  logic [1:0]                r_state;
  logic [1:0]                w_next_state;
  logic [c_CNT_W-1:0]        r_node_cnt;
  logic                      r_sender_en;
  logic [INTERNAL_WIDTH-1:0] r_sender_data;
  logic                      r_tree_loaded;
  logic                      r_load_done;
  logic                      r_search_done;
  logic [PATCH_WIDTH-1:0]    r_patch;
  logic [TREE_LATENCY-1:0]   r_inflight;
  logic [TREE_LATENCY-1:0]   r_lastbit;
  logic [ADDRESS_WIDTH:0]    r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]        r_wr_ptr;
  logic [c_PTR_W-1:0]        r_rd_ptr;
  logic [c_PTR_W:0]          r_count;
  logic [c_OUT_W-1:0]        w_inflight_cnt;
  logic [c_OUT_W-1:0]        w_outstanding;

  logic w_load_begin, w_load_complete, w_drain_complete;
  logic w_node_accept, w_query_accept, w_push, w_pop;

  assign w_load_begin     = (r_state == c_IDLE) && load_start;
  assign w_load_complete  = (r_state == c_LOAD) && (r_node_cnt == c_LAST_NODE);
  assign w_drain_complete = (r_state == c_DRAIN) && (r_inflight == '0) && (r_count == '0);
  assign w_node_accept    = node_valid && node_ready;
  assign w_query_accept   = query_valid && query_ready;
  assign w_push           = r_inflight[TREE_LATENCY-1];
  assign w_pop            = result_valid && result_ready;

  // Credits count every query that will eventually need a FIFO slot.
  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < TREE_LATENCY; i++) begin
      w_inflight_cnt = w_inflight_cnt + c_OUT_W'(r_inflight[i]);
    end
  end
  assign w_outstanding = w_inflight_cnt + c_OUT_W'(r_count);

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (load_start)                        w_next_state = c_LOAD;
        else if (search_start && r_tree_loaded) w_next_state = c_SEARCH;
      end
      c_LOAD:   if (w_load_complete)              w_next_state = c_IDLE;
      c_SEARCH: if (w_query_accept && query_last) w_next_state = c_DRAIN;
      c_DRAIN:  if (w_drain_complete)             w_next_state = c_IDLE;
      default:                                    w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    node_ready      = 1'b0;
    query_ready     = 1'b0;
    tree_fsm_enable = 1'b0;
    busy            = (r_state != c_IDLE);
    case (r_state)
      c_LOAD: begin
        tree_fsm_enable = 1'b1;
        node_ready      = (r_node_cnt != c_LAST_NODE);
      end
      c_SEARCH: query_ready = (w_outstanding < c_CREDITS);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_node_cnt    <= '0;
      r_sender_en   <= 1'b0;
      r_sender_data <= '0;
      r_tree_loaded <= 1'b0;
      r_load_done   <= 1'b0;
    end else begin
      r_sender_en <= w_node_accept;
      r_load_done <= w_load_complete;
      if (w_node_accept) begin
        r_sender_data <= node_data;
        r_node_cnt    <= r_node_cnt + c_CNT_W'(1);
      end else if (w_load_begin) begin
        r_node_cnt <= '0;
      end
      if (w_load_begin)         r_tree_loaded <= 1'b0;
      else if (w_load_complete) r_tree_loaded <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_patch       <= '0;
      r_inflight    <= '0;
      r_lastbit     <= '0;
      r_search_done <= 1'b0;
    end else begin
      r_search_done <= w_drain_complete;
      if (w_query_accept) r_patch <= query_patch;
      for (int i = TREE_LATENCY - 1; i > 0; i--) begin
        r_inflight[i] <= r_inflight[i-1];
        r_lastbit[i]  <= r_lastbit[i-1];
      end
      r_inflight[0] <= w_query_accept;
      r_lastbit[0]  <= w_query_accept && query_last;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_lastbit[TREE_LATENCY-1], tree_leaf_index};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign tree_sender_enable = r_sender_en;
  assign tree_sender_data   = r_sender_data;
  assign tree_patch         = r_patch;
  assign tree_loaded        = r_tree_loaded;
  assign load_done          = r_load_done;
  assign search_done        = r_search_done;
  assign result_valid       = (r_count != '0);
  // Stale FIFO contents are masked so an empty FIFO presents zeros.
  assign result_leaf        = result_valid ? r_mem[r_rd_ptr][ADDRESS_WIDTH-1:0] : '0;
  assign result_last        = result_valid ? r_mem[r_rd_ptr][ADDRESS_WIDTH] : 1'b0;

endmodule
`default_nettype wire
